mem_port_arbiter: RTL and testbench

// - Shares the single memory bus between IF (instruction fetch, read-only) and MEM (data load/store).
// - Generates if_stall / mem_stall for the hazard control unit; mem_stall freezes the whole pipeline.
// - Non-preemptive: one bus transaction at a time, registered bus outputs, variable-latency ack.

---
 rtl/mem_port_arbiter_pkg.sv | 17 +
 rtl/mem_port_arbiter_if.sv | 53 +++++
 rtl/arb_timeout_cnt.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and constants for the IF/MEM bus arbiter
//   arb_state_e  : arbiter states (ARB_IDLE, ARB_DATA, ARB_INST)
//   ARB_SRC_*    : bus_err_src encodings (0 = fetch, 1 = data)
//   ARB_FETCH_BE : byte enables driven for every instruction fetch
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_DATA = 2'd1,
      ARB_INST = 2'd2
   } arb_state_e;

   localparam logic       ARB_SRC_INST = 1'b0;
   localparam logic       ARB_SRC_DATA = 1'b1;
   localparam logic [3:0] ARB_FETCH_BE = 4'hf;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - pipeline-side and memory-bus-side signals of the arbiter
//   if_*  : fetch port (if_req/if_addr/if_cancel in, if_rdata/if_ready/if_stall out)
//   dm_*  : data port (dm_req/dm_we/dm_be/dm_addr/dm_wdata in, dm_rdata/dm_ready out), mem_stall out
//   bus_* : shared memory bus (req/we/be/addr/wdata/err/err_src out, rdata/ack in)
//   modport master : the arbiter, which masters the memory bus
//   modport slave  : the surrounding pipeline and memory
interface mem_port_arbiter_if;

   logic        if_req;
   logic [31:0] if_addr;
   logic        if_cancel;
   logic [31:0] if_rdata;
   logic        if_ready;
   logic        if_stall;

   logic        dm_req;
   logic        dm_we;
   logic [3:0]  dm_be;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_ready;
   logic        mem_stall;

   logic        bus_req;
   logic        bus_we;
   logic [3:0]  bus_be;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ack;
   logic        bus_err;
   logic        bus_err_src;

   modport master (
      input  if_req, if_addr, if_cancel,
      input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
      input  bus_rdata, bus_ack,
      output if_rdata, if_ready, if_stall,
      output dm_rdata, dm_ready, mem_stall,
      output bus_req, bus_we, bus_be, bus_addr, bus_wdata, bus_err, bus_err_src
   );

   modport slave (
      output if_req, if_addr, if_cancel,
      output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
      output bus_rdata, bus_ack,
      input  if_rdata, if_ready, if_stall,
      input  dm_rdata, dm_ready, mem_stall,
      input  bus_req, bus_we, bus_be, bus_addr, bus_wdata, bus_err, bus_err_src
   );

endinterface

// File: rtl/arb_timeout_cnt.sv
// rtl/arb_timeout_cnt.sv - bus-request watchdog counter, present only with ARB_TIMEOUT_EN
//   clk, reset : clock, synchronous active-high reset
//   clr        : restart the count (arbiter idle / granting)
//   en         : count this cycle (bus_req high)
//   expire     : high in the LIMIT-th consecutive enabled cycle
`ifdef ARB_TIMEOUT_EN
module arb_timeout_cnt #(
   parameter int TO_W  = 8,
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expire
);

   logic [TO_W-1:0] cnt_q;
   logic [TO_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // cnt_q holds the number of earlier enabled cycles, so LIMIT-1 marks the LIMIT-th one.
   assign expire = en & ~clr & (cnt_q == TO_W'(LIMIT - 1));

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - non-preemptive arbiter sharing one memory bus between fetch and data
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   arb   : mem_port_arbiter_if.master (fetch port, data port, memory bus)
//   ARB_TIMEOUT_EN : when defined, a bus_req left unacknowledged for TIMEOUT_CYCLES
//                    cycles is aborted with a bus_err pulse; otherwise bus_err/bus_err_src are 0
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TO_W           = 8
)
(
   input logic                clk,
   input logic                reset,
   mem_port_arbiter_if.master arb
);

   arb_state_e  state_q, state_d;
   logic        bus_req_q, bus_req_d;
   logic        bus_we_q, bus_we_d;
   logic [3:0]  bus_be_q, bus_be_d;
   logic [31:0] bus_addr_q, bus_addr_d;
   logic [31:0] bus_wdata_q, bus_wdata_d;
   logic [31:0] if_rdata_q, if_rdata_d;
   logic        if_ready_q, if_ready_d;
   logic [31:0] dm_rdata_q, dm_rdata_d;
   logic        dm_ready_q, dm_ready_d;
   logic        cancel_q, cancel_d;
   logic        fetch_dropped;

   // A cancel arriving in the very cycle of the ack must also discard the word.
   assign fetch_dropped = cancel_q | arb.if_cancel;

`ifdef ARB_TIMEOUT_EN
   logic bus_err_q, bus_err_d;
   logic bus_err_src_q, bus_err_src_d;
   logic to_expire;

   // Every grant is made from IDLE, so holding the counter clear there restarts it per transaction.
   arb_timeout_cnt #(
      .TO_W  (TO_W),
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .clr    (state_q == ARB_IDLE),
      .en     (bus_req_q),
      .expire (to_expire)
   );
`endif

   always_comb begin
      state_d     = state_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_be_d    = bus_be_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      if_rdata_d  = if_rdata_q;
      if_ready_d  = 1'b0;
      dm_rdata_d  = dm_rdata_q;
      dm_ready_d  = 1'b0;
      cancel_d    = cancel_q;
`ifdef ARB_TIMEOUT_EN
      bus_err_d     = 1'b0;
      bus_err_src_d = bus_err_src_q;
`endif

      case (state_q)
         ARB_IDLE: begin
            // A requester whose ready is high is finishing now; skipping it lets a
            // pending fetch win right after a data transfer, so fetch cannot starve.
            if (arb.dm_req && !dm_ready_q) begin
               state_d     = ARB_DATA;
               bus_req_d   = 1'b1;
               bus_we_d    = arb.dm_we;
               bus_be_d    = arb.dm_be;
               bus_addr_d  = arb.dm_addr;
               bus_wdata_d = arb.dm_wdata;
            end else if (arb.if_req && !arb.if_cancel && !if_ready_q) begin
               state_d    = ARB_INST;
               bus_req_d  = 1'b1;
               bus_we_d   = 1'b0;
               bus_be_d   = ARB_FETCH_BE;
               bus_addr_d = arb.if_addr;
            end
         end

         ARB_DATA: begin
            if (arb.bus_ack) begin
               state_d    = ARB_IDLE;
               bus_req_d  = 1'b0;
               dm_rdata_d = arb.bus_rdata;
               dm_ready_d = 1'b1;
            end
`ifdef ARB_TIMEOUT_EN
            else if (to_expire) begin
               state_d       = ARB_IDLE;
               bus_req_d     = 1'b0;
               dm_rdata_d    = '0;
               dm_ready_d    = 1'b1;
               bus_err_d     = 1'b1;
               bus_err_src_d = ARB_SRC_DATA;
            end
`endif
         end

         ARB_INST: begin
            if (arb.if_cancel) begin
               cancel_d = 1'b1;
            end
            if (arb.bus_ack) begin
               state_d   = ARB_IDLE;
               bus_req_d = 1'b0;
               cancel_d  = 1'b0;
               if (!fetch_dropped) begin
                  if_rdata_d = arb.bus_rdata;
                  if_ready_d = 1'b1;
               end
            end
`ifdef ARB_TIMEOUT_EN
            else if (to_expire) begin
               state_d       = ARB_IDLE;
               bus_req_d     = 1'b0;
               cancel_d      = 1'b0;
               bus_err_d     = 1'b1;
               bus_err_src_d = ARB_SRC_INST;
               if (!fetch_dropped) begin
                  if_rdata_d = '0;
                  if_ready_d = 1'b1;
               end
            end
`endif
         end

         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ARB_IDLE;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_be_q    <= '0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         if_rdata_q  <= '0;
         if_ready_q  <= 1'b0;
         dm_rdata_q  <= '0;
         dm_ready_q  <= 1'b0;
         cancel_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_be_q    <= bus_be_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         if_rdata_q  <= if_rdata_d;
         if_ready_q  <= if_ready_d;
         dm_rdata_q  <= dm_rdata_d;
         dm_ready_q  <= dm_ready_d;
         cancel_q    <= cancel_d;
      end
   end

`ifdef ARB_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         bus_err_q     <= 1'b0;
         bus_err_src_q <= 1'b0;
      end else begin
         bus_err_q     <= bus_err_d;
         bus_err_src_q <= bus_err_src_d;
      end
   end

   assign arb.bus_err     = bus_err_q;
   assign arb.bus_err_src = bus_err_src_q;
`else
   assign arb.bus_err     = 1'b0;
   assign arb.bus_err_src = 1'b0;
`endif

   assign arb.bus_req   = bus_req_q;
   assign arb.bus_we    = bus_we_q;
   assign arb.bus_be    = bus_be_q;
   assign arb.bus_addr  = bus_addr_q;
   assign arb.bus_wdata = bus_wdata_q;
   assign arb.if_rdata  = if_rdata_q;
   assign arb.if_ready  = if_ready_q;
   assign arb.dm_rdata  = dm_rdata_q;
   assign arb.dm_ready  = dm_ready_q;

   assign arb.if_stall  = arb.if_req & ~if_ready_q;
   assign arb.mem_stall = arb.dm_req & ~dm_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   typedef struct packed {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } exp_t;

   exp_t exp_q[$];

   mem_port_arbiter_if bus_if ();

   mem_port_arbiter #(.TIMEOUT_CYCLES(8), .TO_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .arb   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic we, input logic [3:0] be, input logic [31:0] addr,
                           input logic [31:0] wdata);
      exp_t e;
      e.we    = we;
      e.be    = be;
      e.addr  = addr;
      e.wdata = wdata;
      exp_q.push_back(e);
   endtask

   // Called in the first cycle bus_req is high: compare the granted transfer with the oldest expectation.
   task automatic expect_bus(input string tag);
      exp_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s_scoreboard: observed empty queue expected an entry", tag);
      end else begin
         e = exp_q.pop_front();
         check({tag, "_bus_req"}, 32'(bus_if.bus_req), 32'd1);
         check({tag, "_bus_we"}, 32'(bus_if.bus_we), 32'(e.we));
         check({tag, "_bus_be"}, 32'(bus_if.bus_be), 32'(e.be));
         check({tag, "_bus_addr"}, bus_if.bus_addr, e.addr);
         if (e.we) check({tag, "_bus_wdata"}, bus_if.bus_wdata, e.wdata);
      end
   endtask

   // Data transfer acked in the ack_cycle-th cycle of bus_req.
   task automatic run_data(input string tag, input logic we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int ack_cycle);
      int stall_n;
      int ready_n;
      stall_n = 0;
      ready_n = 0;
      push_exp(we, be, addr, wdata);
      bus_if.dm_req   = 1'b1;
      bus_if.dm_we    = we;
      bus_if.dm_be    = be;
      bus_if.dm_addr  = addr;
      bus_if.dm_wdata = wdata;
      #1;
      if (bus_if.mem_stall) stall_n++;
      if (bus_if.dm_ready) ready_n++;
      tick();
      expect_bus(tag);
      for (int c = 1; c <= ack_cycle; c++) begin
         if (c > 1) check({tag, "_req_held"}, 32'(bus_if.bus_req), 32'd1);
         if (c == ack_cycle) begin
            bus_if.bus_ack   = 1'b1;
            bus_if.bus_rdata = rdata;
         end
         #1;
         if (bus_if.mem_stall) stall_n++;
         if (bus_if.dm_ready) ready_n++;
         tick();
         bus_if.bus_ack   = 1'b0;
         bus_if.bus_rdata = '0;
      end
      if (bus_if.dm_ready) ready_n++;
      if (!we) check({tag, "_dm_rdata"}, bus_if.dm_rdata, rdata);
      check({tag, "_bus_req_drop"}, 32'(bus_if.bus_req), 32'd0);
      check({tag, "_stall_clear"}, 32'(bus_if.mem_stall), 32'd0);
      check({tag, "_stall_cycles"}, 32'(stall_n), 32'(ack_cycle + 1));
      bus_if.dm_req = 1'b0;
      tick();
      if (bus_if.dm_ready) ready_n++;
      check({tag, "_ready_pulses"}, 32'(ready_n), 32'd1);
   endtask

   initial begin
      checks           = 0;
      errors           = 0;
      reset            = 1'b1;
      bus_if.if_req    = 1'b0;
      bus_if.if_addr   = '0;
      bus_if.if_cancel = 1'b0;
      bus_if.dm_req    = 1'b0;
      bus_if.dm_we     = 1'b0;
      bus_if.dm_be     = '0;
      bus_if.dm_addr   = '0;
      bus_if.dm_wdata  = '0;
      bus_if.bus_rdata = '0;
      bus_if.bus_ack   = 1'b0;
      tick();
      tick();

      check("rst_bus_req", 32'(bus_if.bus_req), 32'd0);
      check("rst_bus_we", 32'(bus_if.bus_we), 32'd0);
      check("rst_bus_addr", bus_if.bus_addr, 32'd0);
      check("rst_if_ready", 32'(bus_if.if_ready), 32'd0);
      check("rst_dm_ready", 32'(bus_if.dm_ready), 32'd0);
      check("rst_bus_err", 32'(bus_if.bus_err), 32'd0);
      reset = 1'b0;
      tick();

      // Single load, ack in the third bus_req cycle: four stall cycles.
      run_data("load", 1'b0, 4'hf, 32'h100, 32'h0, 32'hDEADBEEF, 3);

      // Contention: both request in cycle 0, zero-wait acks.
      push_exp(1'b0, 4'hf, 32'h200, 32'h0);
      push_exp(1'b0, 4'hf, 32'h40, 32'h0);
      bus_if.dm_req  = 1'b1;
      bus_if.dm_we   = 1'b0;
      bus_if.dm_be   = 4'hf;
      bus_if.dm_addr = 32'h200;
      bus_if.if_req  = 1'b1;
      bus_if.if_addr = 32'h40;
      #1;
      check("cont_c0_mem_stall", 32'(bus_if.mem_stall), 32'd1);
      check("cont_c0_if_stall", 32'(bus_if.if_stall), 32'd1);
      tick();
      expect_bus("cont_c1_data");
      bus_if.bus_ack   = 1'b1;
      bus_if.bus_rdata = 32'h11112222;
      tick();
      bus_if.bus_ack   = 1'b0;
      check("cont_c2_dm_ready", 32'(bus_if.dm_ready), 32'd1);
      check("cont_c2_dm_rdata", bus_if.dm_rdata, 32'h11112222);
      check("cont_c2_if_stall", 32'(bus_if.if_stall), 32'd1);
      tick();
      bus_if.dm_req = 1'b0;
      expect_bus("cont_c3_inst");
      bus_if.bus_ack   = 1'b1;
      bus_if.bus_rdata = 32'hCAFEF00D;
      tick();
      bus_if.bus_ack   = 1'b0;
      check("cont_c4_if_ready", 32'(bus_if.if_ready), 32'd1);
      check("cont_c4_if_rdata", bus_if.if_rdata, 32'hCAFEF00D);
      check("cont_c4_if_stall", 32'(bus_if.if_stall), 32'd0);
      bus_if.if_req = 1'b0;
      tick();
      check("cont_c5_if_ready", 32'(bus_if.if_ready), 32'd0);

      // Cancel one cycle after the fetch grant, then a redirected fetch.
      push_exp(1'b0, 4'hf, 32'h80, 32'h0);
      bus_if.if_req  = 1'b1;
      bus_if.if_addr = 32'h80;
      tick();
      expect_bus("cancel_c1");
      bus_if.if_req    = 1'b0;
      bus_if.if_cancel = 1'b1;
      tick();
      bus_if.if_cancel = 1'b0;
      push_exp(1'b0, 4'hf, 32'h300, 32'h0);
      bus_if.if_req    = 1'b1;
      bus_if.if_addr   = 32'h300;
      check("cancel_c2_req_held", 32'(bus_if.bus_req), 32'd1);
      bus_if.bus_ack   = 1'b1;
      bus_if.bus_rdata = 32'h12345678;
      tick();
      bus_if.bus_ack   = 1'b0;
      check("cancel_c3_no_ready", 32'(bus_if.if_ready), 32'd0);
      check("cancel_c3_rdata_kept", bus_if.if_rdata, 32'hCAFEF00D);
      check("cancel_c3_bus_req", 32'(bus_if.bus_req), 32'd0);
      tick();
      expect_bus("cancel_c4_refetch");
      bus_if.bus_ack   = 1'b1;
      bus_if.bus_rdata = 32'h0BADCAFE;
      tick();
      bus_if.bus_ack   = 1'b0;
      check("cancel_c5_if_ready", 32'(bus_if.if_ready), 32'd1);
      check("cancel_c5_if_rdata", bus_if.if_rdata, 32'h0BADCAFE);
      bus_if.if_req = 1'b0;
      tick();

      // if_req together with if_cancel in IDLE: no grant.
      bus_if.if_req    = 1'b1;
      bus_if.if_cancel = 1'b1;
      tick();
      check("idle_cancel_no_grant", 32'(bus_if.bus_req), 32'd0);
      bus_if.if_req    = 1'b0;
      bus_if.if_cancel = 1'b0;

      // Stray ack in IDLE is ignored.
      bus_if.bus_ack   = 1'b1;
      bus_if.bus_rdata = 32'h99;
      tick();
      bus_if.bus_ack   = 1'b0;
      check("idle_ack_dm_ready", 32'(bus_if.dm_ready), 32'd0);
      check("idle_ack_if_ready", 32'(bus_if.if_ready), 32'd0);
      check("idle_ack_bus_req", 32'(bus_if.bus_req), 32'd0);

      // Store with partial byte enables.
      run_data("store", 1'b1, 4'b0011, 32'h104, 32'hA5A5, 32'h77777777, 1);

      // Data request that is never acked.
      push_exp(1'b0, 4'hf, 32'h1C0, 32'h0);
      bus_if.dm_req  = 1'b1;
      bus_if.dm_we   = 1'b0;
      bus_if.dm_be   = 4'hf;
      bus_if.dm_addr = 32'h1C0;
      tick();
      expect_bus("timeout");
`ifdef ARB_TIMEOUT_EN
      for (int c = 1; c <= 8; c++) begin
         check("timeout_req_held", 32'(bus_if.bus_req), 32'd1);
         check("timeout_no_err_yet", 32'(bus_if.bus_err), 32'd0);
         tick();
      end
      check("timeout_bus_err", 32'(bus_if.bus_err), 32'd1);
      check("timeout_err_src", 32'(bus_if.bus_err_src), 32'd1);
      check("timeout_dm_ready", 32'(bus_if.dm_ready), 32'd1);
      check("timeout_dm_rdata", bus_if.dm_rdata, 32'd0);
      check("timeout_bus_req", 32'(bus_if.bus_req), 32'd0);
      bus_if.dm_req = 1'b0;
      tick();
      check("timeout_err_pulse", 32'(bus_if.bus_err), 32'd0);
`else
      for (int c = 1; c <= 20; c++) tick();
      check("no_timeout_stall", 32'(bus_if.mem_stall), 32'd1);
      check("no_timeout_bus_req", 32'(bus_if.bus_req), 32'd1);
      check("no_timeout_bus_err", 32'(bus_if.bus_err), 32'd0);
      bus_if.bus_ack   = 1'b1;
      bus_if.bus_rdata = 32'h31415926;
      tick();
      bus_if.bus_ack   = 1'b0;
      check("no_timeout_late_ready", 32'(bus_if.dm_ready), 32'd1);
      bus_if.dm_req = 1'b0;
      tick();
`endif

      // Reset in the middle of a data transfer, then a late ack.
      push_exp(1'b0, 4'b0110, 32'h180, 32'h5555);
      bus_if.dm_req   = 1'b1;
      bus_if.dm_we    = 1'b0;
      bus_if.dm_be    = 4'b0110;
      bus_if.dm_addr  = 32'h180;
      bus_if.dm_wdata = 32'h5555;
      tick();
      expect_bus("midrst");
      reset = 1'b1;
      tick();
      check("midrst_bus_req", 32'(bus_if.bus_req), 32'd0);
      check("midrst_bus_be", 32'(bus_if.bus_be), 32'd0);
      check("midrst_bus_addr", bus_if.bus_addr, 32'd0);
      check("midrst_bus_wdata", bus_if.bus_wdata, 32'd0);
      check("midrst_if_rdata", bus_if.if_rdata, 32'd0);
      check("midrst_dm_rdata", bus_if.dm_rdata, 32'd0);
      check("midrst_dm_ready", 32'(bus_if.dm_ready), 32'd0);
      reset            = 1'b0;
      bus_if.dm_req    = 1'b0;
      bus_if.bus_ack   = 1'b1;
      bus_if.bus_rdata = 32'hFEEDFACE;
      tick();
      bus_if.bus_ack   = 1'b0;
      check("late_ack_dm_ready", 32'(bus_if.dm_ready), 32'd0);
      check("late_ack_dm_rdata", bus_if.dm_rdata, 32'd0);
      check("late_ack_bus_req", 32'(bus_if.bus_req), 32'd0);
      check("late_ack_mem_stall", 32'(bus_if.mem_stall), 32'd0);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
